// File: rtl/fp_arb_pkg.sv
// Shared types and helpers for the FP round-robin arbiter slice.
package fp_arb_pkg;

  localparam int CNT_W = 16;

  typedef logic [CNT_W-1:0] grant_cnt_t;

  // Pointer advance with wrap at num_req, so non-power-of-two sizes wrap correctly.
  function automatic logic [31:0] rr_next_ptr(input logic [31:0] g, input logic [31:0] num_req);
    logic [31:0] nxt;
    if (g >= num_req - 32'd1) begin
      nxt = 32'd0;
    end else begin
      nxt = g + 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/fp_rr_prio_find.sv
// Lowest-set-index finder over NUM_REQ bits, built as a binary reduction tree.
module fp_rr_prio_find
  import fp_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] vec,
  output logic [IDX_W-1:0]   idx,
  output logic               empty
);

  localparam int P = 1 << IDX_W;

  logic [P-1:0]     vec_pad_s;
  logic [P-1:0]     empty_lv_s [IDX_W+1];
  logic [IDX_W-1:0] idx_lv_s   [IDX_W+1][P];

  // Tree levels: each node keeps the left child's index unless the left subtree is empty.
  always_comb begin
    vec_pad_s = '0;
    vec_pad_s[NUM_REQ-1:0] = vec;
    for (int l = 0; l <= IDX_W; l++) begin
      empty_lv_s[l] = '1;
      for (int i = 0; i < P; i++) begin
        idx_lv_s[l][i] = '0;
      end
    end
    for (int i = 0; i < P; i++) begin
      empty_lv_s[0][i] = ~vec_pad_s[i];
      idx_lv_s[0][i]   = IDX_W'(i);
    end
    for (int l = 1; l <= IDX_W; l++) begin
      for (int i = 0; i < (P >> l); i++) begin
        empty_lv_s[l][i] = empty_lv_s[l-1][2*i] & empty_lv_s[l-1][2*i+1];
        if (empty_lv_s[l-1][2*i]) begin
          idx_lv_s[l][i] = idx_lv_s[l-1][2*i+1];
        end else begin
          idx_lv_s[l][i] = idx_lv_s[l-1][2*i];
        end
      end
    end
  end

  assign idx   = idx_lv_s[IDX_W][0];
  assign empty = empty_lv_s[IDX_W][0];

endmodule

// File: rtl/fp_rr_arbiter.sv
// Round-robin arbiter feeding one shared FP stage through a registered output slot.
// Optional per-requester grant counters are enabled with FP_RR_ARBITER_STATS_EN.
module fp_rr_arbiter
  import fp_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 32,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DATA_W-1:0]          out_data_o,
  output logic [IDX_W-1:0]           out_idx_o,
  output logic [NUM_REQ*CNT_W-1:0]   grant_cnt_o
);

  logic [IDX_W-1:0]   ptr_r;
  logic               out_valid_r;
  logic [DATA_W-1:0]  out_data_r;
  logic [IDX_W-1:0]   out_idx_r;

  logic [NUM_REQ-1:0] masked_s;
  logic [IDX_W-1:0]   m_idx_s;
  logic               m_empty_s;
  logic [IDX_W-1:0]   u_idx_s;
  logic               u_empty_s;
  logic [IDX_W-1:0]   win_s;
  logic               any_req_s;
  logic               load_en_s;
  logic               grant_s;
  logic [NUM_REQ-1:0] ready_s;
  logic [IDX_W-1:0]   next_ptr_s;
  logic [DATA_W-1:0]  win_data_s;

  // Requests at or above the pointer get first pick.
  always_comb begin
    masked_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      masked_s[i] = req_valid_i[i] & (32'(i) >= 32'(ptr_r));
    end
  end

  fp_rr_prio_find #(.NUM_REQ(NUM_REQ)) u_find_masked (
    .vec   (masked_s),
    .idx   (m_idx_s),
    .empty (m_empty_s)
  );

  fp_rr_prio_find #(.NUM_REQ(NUM_REQ)) u_find_all (
    .vec   (req_valid_i),
    .idx   (u_idx_s),
    .empty (u_empty_s)
  );

  // Winner select and grant; ready is held low while reset is asserted.
  always_comb begin
    load_en_s = !flush_i && (!out_valid_r || out_ready_i);
    any_req_s = !u_empty_s;
    if (!m_empty_s) begin
      win_s = m_idx_s;
    end else begin
      win_s = u_idx_s;
    end
    grant_s = load_en_s && any_req_s;
    if (grant_s && rst_ni) begin
      ready_s = NUM_REQ'(1'b1) << win_s;
    end else begin
      ready_s = '0;
    end
    next_ptr_s = IDX_W'(rr_next_ptr(32'(win_s), 32'(NUM_REQ)));
    win_data_s = req_data_i[32'(win_s)*DATA_W +: DATA_W];
  end

  // Output slot and pointer; flush drops the held item but keeps data/idx.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_idx_r   <= '0;
      ptr_r       <= '0;
    end else if (flush_i) begin
      out_valid_r <= 1'b0;
      ptr_r       <= '0;
    end else if (grant_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= win_data_s;
      out_idx_r   <= win_s;
      ptr_r       <= next_ptr_s;
    end else if (load_en_s) begin
      out_valid_r <= 1'b0;
    end
  end

`ifdef FP_RR_ARBITER_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    grant_cnt_t cnt_r;

    // Saturating handshake counter, untouched by flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_r <= '0;
      end else if (ready_s[g] && req_valid_i[g] && (cnt_r != 16'hFFFF)) begin
        cnt_r <= cnt_r + 16'd1;
      end
    end

    assign grant_cnt_o[g*CNT_W +: CNT_W] = cnt_r;
  end
`else
  assign grant_cnt_o = '0;
`endif

  assign req_ready_o = ready_s;
  assign out_valid_o = out_valid_r;
  assign out_data_o  = out_data_r;
  assign out_idx_o   = out_idx_r;

endmodule

// File: tb/tb_fp_rr_arbiter.sv
// Directed table-driven bench for fp_rr_arbiter (NUM_REQ=4, DATA_W=32).
module tb_fp_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int IDX_W   = 2;

  typedef struct {
    logic [3:0] valid;
    logic       oready;
    logic       flush;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [1:0] exp_idx;
  } vec_t;

  logic                      clk = 1'b0;
  logic                      rst_ni;
  logic                      flush_i;
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic                      out_valid_o;
  logic                      out_ready_i;
  logic [DATA_W-1:0]         out_data_o;
  logic [IDX_W-1:0]          out_idx_o;
  logic [NUM_REQ*16-1:0]     grant_cnt_o;

  int checks = 0;
  int errors = 0;
  int unsigned model_cnt [NUM_REQ];
  vec_t vq[$];

  always #5 clk = ~clk;

  fp_rr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_data_i  (req_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_idx_o   (out_idx_o),
    .grant_cnt_o (grant_cnt_o)
  );

  function automatic logic [31:0] lane_data(input int i);
    return 32'hF00D_0005 + 32'(i) * 32'h0101_1111;
  endfunction

  function automatic logic [63:0] exp_cnt();
    logic [63:0] r;
    r = '0;
`ifdef FP_RR_ARBITER_STATS_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      r[i*16 +: 16] = 16'(model_cnt[i]);
    end
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_grant(input logic [3:0] rdy);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rdy[i] && model_cnt[i] < 32'd65535) model_cnt[i]++;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NUM_REQ; i++) model_cnt[i] = 0;
  endtask

  initial begin
    // rdy/ov/idx: expected ready this cycle, out_valid/out_idx after the edge
    vq.push_back('{4'hF, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0});
    vq.push_back('{4'hF, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1});
    vq.push_back('{4'hF, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2});
    vq.push_back('{4'hF, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3});
    vq.push_back('{4'hF, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0});
    vq.push_back('{4'hF, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1});
    vq.push_back('{4'h9, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3});
    vq.push_back('{4'h9, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0});
    vq.push_back('{4'h0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0});
    vq.push_back('{4'hF, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1});
    for (int k = 0; k < 5; k++) vq.push_back('{4'hF, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1});
    vq.push_back('{4'hF, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2});
    vq.push_back('{4'hF, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd2});
    vq.push_back('{4'hF, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0});
    vq.push_back('{4'h4, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2});
    vq.push_back('{4'h3, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0});
    vq.push_back('{4'h5, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2});
    vq.push_back('{4'h8, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2});
    vq.push_back('{4'h8, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3});
    vq.push_back('{4'h0, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd3});
    vq.push_back('{4'h0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd3});

    for (int i = 0; i < NUM_REQ; i++) req_data_i[i*DATA_W +: DATA_W] = lane_data(i);
    clear_model();
    rst_ni      = 1'b0;
    flush_i     = 1'b0;
    out_ready_i = 1'b1;
    req_valid_i = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 64'(out_valid_o), 64'd0);
    check("reset_data",  64'(out_data_o),  64'd0);
    check("reset_idx",   64'(out_idx_o),   64'd0);
    check("reset_ready", 64'(req_ready_o), 64'd0);
    check("reset_cnt",   grant_cnt_o,      64'd0);
    req_valid_i = 4'h0;
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < vq.size(); k++) begin
      req_valid_i = vq[k].valid;
      out_ready_i = vq[k].oready;
      flush_i     = vq[k].flush;
      #1;
      check($sformatf("v%0d_ready", k), 64'(req_ready_o), 64'(vq[k].exp_rdy));
      @(posedge clk);
      #1;
      model_grant(vq[k].exp_rdy);
      check($sformatf("v%0d_valid", k), 64'(out_valid_o), 64'(vq[k].exp_ov));
      check($sformatf("v%0d_idx", k),   64'(out_idx_o),   64'(vq[k].exp_idx));
      check($sformatf("v%0d_data", k),  64'(out_data_o),  64'(lane_data(int'(vq[k].exp_idx))));
      check($sformatf("v%0d_cnt", k),   grant_cnt_o,      exp_cnt());
    end
    flush_i = 1'b0;

    // Grant lane 0 so ptr=1 and out_valid=1, then reset in mid-cycle.
    req_valid_i = 4'hF;
    out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst_valid", 64'(out_valid_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid_o), 64'd0);
    check("async_rst_ready", 64'(req_ready_o), 64'd0);
    clear_model();
    req_valid_i = 4'h0;
    @(negedge clk);
    rst_ni      = 1'b1;
    req_valid_i = 4'hF;
    #1;
    check("post_rst_ready", 64'(req_ready_o), 64'b0001);
    @(posedge clk);
    #1;
    model_grant(4'b0001);
    check("post_rst_idx",   64'(out_idx_o),   64'd0);
    check("post_rst_valid", 64'(out_valid_o), 64'd1);
    check("post_rst_cnt",   grant_cnt_o,      exp_cnt());

    // Long run on lane 0 only: counter saturates with stats, stays 0 without.
    req_valid_i = 4'b0001;
    for (int n = 0; n < 70000; n++) begin
      @(posedge clk);
      model_grant(4'b0001);
    end
    #1;
    check("sat_ready", 64'(req_ready_o), 64'b0001);
    check("sat_cnt",   grant_cnt_o,      exp_cnt());
`ifdef FP_RR_ARBITER_STATS_EN
    check("sat_cnt0", 64'(grant_cnt_o[15:0]), 64'hFFFF);
`else
    check("nostats_cnt", grant_cnt_o, 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_rr_arbiter.md
Name: fp_rr_arbiter

Overview:
- Round-robin arbiter: shares one downstream valid/ready consumer (e.g. a shared FP normalisation/packing stage) among NUM_REQ upstream requesters.
- Winner selection uses a leading-one / priority-find datapath over a pointer-masked request vector.
- The winner's payload and index go into a single registered output stage.
- Sits between per-lane FP producers and one shared FP unit.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..32.
- DATA_W, 32, payload width in bits.
- IDX_W, $clog2(NUM_REQ), localparam; width of requester index and pointer.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous clear of output stage and pointer.
- req_valid_i  in  NUM_REQ  per-requester valid.
- req_ready_o  out  NUM_REQ  per-requester ready; one-hot or zero.
- req_data_i  in  NUM_REQ x DATA_W  per-requester payload, packed, requester 0 in the LSBs.
- out_valid_o  out  1  registered output valid.
- out_ready_i  in  1  downstream ready.
- out_data_o  out  DATA_W  registered winning payload.
- out_idx_o  out  IDX_W  registered index of the winner.
- grant_cnt_o  out  NUM_REQ x 16  per-requester grant counters (optional feature).

Behaviour:
- Reset (rst_ni low, async): out_valid_o=0, out_data_o=0, out_idx_o=0, pointer ptr=0, grant_cnt_o=0. req_ready_o is all-zero while in reset.
- Load enable: load_en = !flush_i && (!out_valid_o || out_ready_i).
- Arbitration (combinational):
  - masked = req_valid_i with bits below ptr cleared.
  - If masked is nonzero, the winner g is the lowest set index in masked.
  - Otherwise g is the lowest set index in req_valid_i.
  - any_req = |req_valid_i.
- Grant: req_ready_o[g]=1 iff load_en && any_req; all other bits are 0. req_ready_o never depends on req_data_i.
- On grant (next edge):
  - out_valid_o<=1, out_data_o<=req_data_i[g], out_idx_o<=g.
  - ptr <= g+1, wrapping to 0 when g = NUM_REQ-1.
- Latency: 1 cycle from req handshake to out_valid_o.
- Throughput: 1 grant per cycle when out_ready_i is held high. Output consume and new load in the same cycle give no bubble.
- Output consumed with no request: load_en && !any_req gives out_valid_o<=0. Data and idx keep their last values; ptr is unchanged.
- Backpressure: while out_valid_o && !out_ready_i, out_data_o, out_idx_o and ptr are stable, and req_ready_o is all-zero.
- Flush: flush_i high gives req_ready_o all-zero that cycle. Next edge: out_valid_o<=0 (held item dropped), ptr<=0. Data/idx are not cleared. flush_i wins over a simultaneous out_ready_i.
- Fairness: any continuously asserted requester is granted within NUM_REQ grants.
- Upstream contract: a requester holds req_valid_i and req_data_i until its handshake. Violations are not checked.
- Non-power-of-two NUM_REQ: pointer wrap and index compare use NUM_REQ, not 2**IDX_W.

Optional Feature:
- Macro: FP_RR_ARBITER_STATS_EN.
- Defined:
  - Per-requester 16-bit counters increment on each handshake of that requester.
  - Counters saturate at 0xFFFF and are not cleared by flush_i.
  - grant_cnt_o drives the counters.
- Undefined: grant_cnt_o tied to 0, no counter flops. All other behaviour is identical.

Decomposition:
- Shared package fp_arb_pkg:
  - CNT_W=16.
  - Typedef grant_cnt_t = logic [CNT_W-1:0].
  - Function rr_next_ptr(g, NUM_REQ) for the wrap rule.
- One natural sub-module: fp_rr_prio_find.
  - Lowest-set-index finder over NUM_REQ bits.
  - Outputs idx + none flag, built as a log-depth tree.
  - Instantiated twice: masked and unmasked vectors.
- Top module holds the pointer, output register, grant logic and optional counters.

Test Plan:
1. Reset: assert rst_ni=0 mid-transfer with out_valid_o=1 -> out_valid_o=0, req_ready_o=0 immediately. After release, ptr=0, so the first grant with all valid goes to 0.
2. All four valid, out_ready_i=1 constant -> req_ready_o cycles 0001,0010,0100,1000,0001. out_idx_o follows 0,1,2,3,0 one cycle later, with no bubbles.
3. Backpressure: out_valid_o=1, out_ready_i=0 for 5 cycles -> out_data_o/out_idx_o stable, req_ready_o=0. Raise out_ready_i -> grant in that same cycle, new data next cycle.
4. Sparse: after grant of 1 (ptr=2), req_valid_i=1001 -> grant 3. Next cycle, with 1001 still held, -> grant 0 (wrap).
5. Flush while holding idx 2 with requests pending -> req_ready_o=0 that cycle. Next cycle out_valid_o=0 and ptr=0; a subsequent all-valid request is granted to 0.
6. With FP_RR_ARBITER_STATS_EN: 70000 grants to requester 0 -> grant_cnt_o[0]=0xFFFF, others 0. Without the macro -> grant_cnt_o=0 throughout.
